multi_hot_index_encoder: RTL

- Parametrised, sequential successor to the combinational 8:3 encoder.
- Accepts a WIDTH-bit request vector with any number of bits set (zero, one or many) over a valid/ready handshake.
- Emits the index of every set bit as a stream, one index per beat, in a fixed priority order.
- Sits between request-collection logic (interrupt lines, grant masks) and consumers that service one index at a time.

---
 rtl/multi_hot_index_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multi_hot_index_encoder.sv
// Streams the index of every set bit of a multi-hot vector, one per beat (POPCOUNT_EN adds out_count).
// Latency: first beat 1 cycle after acceptance, then 1 index/cycle; one idle cycle between vectors.
// Backpressure: beat held stable while out_ready=0; in_ready only in IDLE.
module multi_hot_index_encoder #(
   parameter int  WIDTH     = 8,
   parameter bit  MSB_FIRST = 1'b0,
   localparam int IDX_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_none
`ifdef POPCOUNT_EN
   ,
   output logic [IDX_W:0]   out_count
`endif
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   pending_q, pending_d;
   logic               none_q, none_d;
   logic [IDX_W-1:0]   sel_idx;
   logic [WIDTH-1:0]   sel_mask;
   logic               one_hot;

   // Priority select: the last match in loop order wins.
   always_comb begin
      sel_idx  = '0;
      sel_mask = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end
   end

   assign one_hot = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == SCAN);
   assign out_idx   = sel_idx;
   assign out_last  = out_valid && (none_q || one_hot);
   assign out_none  = out_valid && none_q;

`ifdef POPCOUNT_EN
   logic [IDX_W:0] count_q, count_d;
   logic [IDX_W:0] in_pop;

   always_comb begin
      in_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         in_pop = in_pop + (IDX_W + 1)'(in_vec[i]);
      end
   end

   always_comb begin
      count_d = count_q;
      if (state_q == IDLE && in_valid) begin
         count_d = in_pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out_count = out_valid ? count_q : '0;
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      none_d    = none_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               pending_d = in_vec;
               none_d    = (in_vec == '0);
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (out_ready) begin
               pending_d = pending_q & ~sel_mask;
               if (out_last) begin
                  none_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         none_q    <= none_d;
      end
   end

endmodule
